// File: rtl/stream_arb_pkg.sv
// Shared types and the rotated priority search used by the stream stage arbiters.
// Purely declarative. There is no latency and no flow control in this file.
// Backpressure is not applicable here; callers gate the grant with their own load condition.
package stream_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // Beat layout for the default 32-bit data / 16-bit ctrl build.
    typedef struct packed {
        logic [PTR_W-1:0] src_id;
        logic [15:0]      ctrl;
        logic [31:0]      data;
    } arb_beat_t;

    // The scan runs from farthest to nearest, so the index closest to ptr is the last one written and wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [PTR_W-1:0]   ptr,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (valid[j[PTR_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[PTR_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_logic.sv
// Round-robin winner search, rotated by the pointer.
// Latency is 0 because the search is combinational.
// Backpressure is not applicable; the caller qualifies the found flag.
module rr_pick_logic
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int SRC_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   valid_i,
    input  logic [SRC_WIDTH-1:0] ptr_i,
    output logic                 found_o,
    output logic [SRC_WIDTH-1:0] idx_o
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [PTR_W-1:0]   ptr_ext;
    rr_pick_t           pick;
    logic               unused_idx;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid_i;
        ptr_ext                  = '0;
        ptr_ext[SRC_WIDTH-1:0]   = ptr_i;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    end

    assign found_o    = pick.found;
    assign idx_o      = pick.idx[SRC_WIDTH-1:0];
    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that feeds NUM_REQ streams into one registered output.
// Latency is 1 cycle and throughput is 1 beat per cycle. Optional grant counters exist when STREAM_RR_ARBITER_STATS_EN is defined.
// Backpressure: when the output is full and tready is low, every input tready is 0 and the state is held.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            axis_s_data_tvalid,
    output logic [NUM_REQ-1:0]            axis_s_data_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] axis_s_data_tdata,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0] ctrl_data_i,
    output logic                          axis_m_data_tvalid,
    input  logic                          axis_m_data_tready,
    output logic [DATA_WIDTH-1:0]         axis_m_data_tdata,
    output logic [CTRL_WIDTH-1:0]         ctrl_data_o,
`ifdef STREAM_RR_ARBITER_STATS_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt_o,
    input  logic                          stats_clr,
`endif
    output logic [SRC_WIDTH-1:0]          src_id_o
);

    out_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [SRC_WIDTH-1:0]  src_q, src_d;
    logic [SRC_WIDTH-1:0]  ptr_q, ptr_d;

    logic                  found;
    logic [SRC_WIDTH-1:0]  win;
    logic                  load_ok;
    logic                  accept;
    logic [SRC_WIDTH:0]    win_inc;
    logic [DATA_WIDTH-1:0] win_data;
    logic [CTRL_WIDTH-1:0] win_ctrl;

    rr_pick_logic #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .valid_i (axis_s_data_tvalid),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (win)
    );

    assign load_ok = (state_q == ST_EMPTY) || axis_m_data_tready;
    assign accept  = found && load_ok;
    assign win_inc = {1'b0, win} + 1'b1;

    always_comb begin
        win_data = '0;
        win_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == SRC_WIDTH'(i)) begin
                win_data = axis_s_data_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                win_ctrl = ctrl_data_i[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    // The reset term keeps every grant low while reset is asserted, even though the empty register would allow a load.
    always_comb begin
        axis_s_data_tready = '0;
        if (accept && rst) axis_s_data_tready[win] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = win_data;
            ctrl_d  = win_ctrl;
            src_d   = win;
            ptr_d   = (win_inc == (SRC_WIDTH+1)'(NUM_REQ)) ? '0 : win_inc[SRC_WIDTH-1:0];
        end else if (axis_m_data_tready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ctrl_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign axis_m_data_tvalid = (state_q == ST_FULL);
    assign axis_m_data_tdata  = data_q;
    assign ctrl_data_o        = ctrl_q;
    assign src_id_o           = src_q;

`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // A clear wins over an increment that lands in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else if (accept) begin
            cnt_q[win] <= cnt_q[win] + 16'd1;
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt_o[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter in its default two-requester build.
// The grant counter checks are compiled only when STREAM_RR_ARBITER_STATS_EN is defined.
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tready;
    logic [63:0] s_tdata;
    logic [31:0] ctrl_i;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [15:0] ctrl_o;
    logic        src_id;
`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [31:0] grant_cnt;
    logic        stats_clr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .axis_s_data_tvalid (s_tvalid),
        .axis_s_data_tready (s_tready),
        .axis_s_data_tdata  (s_tdata),
        .ctrl_data_i        (ctrl_i),
        .axis_m_data_tvalid (m_tvalid),
        .axis_m_data_tready (m_tready),
        .axis_m_data_tdata  (m_tdata),
        .ctrl_data_o        (ctrl_o),
`ifdef STREAM_RR_ARBITER_STATS_EN
        .grant_cnt_o        (grant_cnt),
        .stats_clr          (stats_clr),
`endif
        .src_id_o           (src_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        s_tvalid = 2'b11;
        s_tdata  = {32'h0000_0B0B, 32'h0000_0A0A};
        ctrl_i   = 32'h0;
        m_tready = 1'b1;
        repeat (3) step();
        total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL rst_tready got=%b want=00", s_tready); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", m_tvalid); end
        total++; if (m_tdata !== 32'h0 || ctrl_o !== 16'h0) begin bad++; $display("FAIL rst_data got=%h/%h want=0/0", m_tdata, ctrl_o); end
        s_tvalid = 2'b00;
        rst      = 1'b1;
        step();
        step();
        total++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || src_id !== 1'b0) begin
            bad++; $display("FAIL idle got=tv%b rdy%b src%b want=0/00/0", m_tvalid, s_tready, src_id);
        end
    endtask

    task automatic test_single();
        s_tvalid = 2'b10;
        s_tdata  = {32'hDEAD_BEEF, 32'h0};
        ctrl_i   = {16'h00A5, 16'h0};
        m_tready = 1'b1;
        #1;
        total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL single_rdy got=%b want=10", s_tready); end
        step();
        s_tvalid = 2'b00;
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hDEAD_BEEF || ctrl_o !== 16'h00A5 || src_id !== 1'b1) begin
            bad++; $display("FAIL single_out got=%b %h %h %b want=1 deadbeef 00a5 1", m_tvalid, m_tdata, ctrl_o, src_id);
        end
        step();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL drain got=%b want=0", m_tvalid); end
    endtask

    task automatic test_fairness();
        logic [5:0] exp_src;
        exp_src  = 6'b101010;
        s_tvalid = 2'b11;
        s_tdata  = {32'hB000_0001, 32'hA000_0000};
        ctrl_i   = {16'h0B0B, 16'h0A0A};
        m_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if (s_tready !== (exp_src[k] ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL fair_rdy[%0d] got=%b want_src=%b", k, s_tready, exp_src[k]);
            end
            step();
            total++; if (m_tvalid !== 1'b1 || src_id !== exp_src[k] ||
                         m_tdata !== (exp_src[k] ? 32'hB000_0001 : 32'hA000_0000)) begin
                bad++; $display("FAIL fair_out[%0d] got=%b src%b %h want=1 src%b", k, m_tvalid, src_id, m_tdata, exp_src[k]);
            end
        end
        s_tvalid = 2'b00;
        step();
    endtask

    task automatic test_idle_ptr();
        s_tvalid = 2'b01;
        s_tdata  = {32'h0000_0002, 32'h0000_0001};
        step();
        s_tvalid = 2'b00;
        repeat (3) step();
        s_tvalid = 2'b11;
        #1;
        total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL idle_ptr got=%b want=10", s_tready); end
        step();
        s_tvalid = 2'b00;
        step();
    endtask

    task automatic test_backpressure();
        s_tvalid = 2'b01;
        s_tdata  = {32'h0, 32'h0000_0011};
        m_tready = 1'b0;
        step();
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h11) begin
            bad++; $display("FAIL bp_load got=%b %h want=1 00000011", m_tvalid, m_tdata);
        end
        s_tvalid = 2'b11;
        s_tdata  = {32'h0000_0033, 32'h0000_0022};
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (s_tready !== 2'b00 || m_tdata !== 32'h11 || src_id !== 1'b0 || m_tvalid !== 1'b1) begin
                bad++; $display("FAIL bp_hold[%0d] got=rdy%b %h src%b want=00 00000011 src0", k, s_tready, m_tdata, src_id);
            end
            step();
        end
        m_tready = 1'b1;
        #1;
        total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL bp_release got=%b want=10", s_tready); end
        step();
        total++; if (m_tdata !== 32'h33 || src_id !== 1'b1) begin bad++; $display("FAIL bp_next got=%h src%b want=00000033 src1", m_tdata, src_id); end
        step();
        total++; if (m_tdata !== 32'h22 || src_id !== 1'b0) begin bad++; $display("FAIL bp_after got=%h src%b want=00000022 src0", m_tdata, src_id); end
        s_tvalid = 2'b00;
        step();
    endtask

    task automatic test_mid_reset();
        s_tvalid = 2'b01;
        s_tdata  = {32'h0000_0055, 32'h0000_0044};
        m_tready = 1'b0;
        step();
        s_tvalid = 2'b00;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL mr_full got=%b want=1", m_tvalid); end
        #1 rst = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin bad++; $display("FAIL mr_async got=%b %h want=0 0", m_tvalid, m_tdata); end
        step();
        rst      = 1'b1;
        s_tvalid = 2'b11;
        m_tready = 1'b1;
        #1;
        total++; if (s_tready !== 2'b01) begin bad++; $display("FAIL mr_first got=%b want=01", s_tready); end
        step();
        total++; if (src_id !== 1'b0 || m_tdata !== 32'h44) begin bad++; $display("FAIL mr_out got=src%b %h want=src0 00000044", src_id, m_tdata); end
        s_tvalid = 2'b00;
        step();
    endtask

`ifdef STREAM_RR_ARBITER_STATS_EN
    task automatic test_stats();
        m_tready  = 1'b1;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        s_tvalid  = 2'b01;
        repeat (5) step();
        s_tvalid = 2'b10;
        repeat (3) step();
        s_tvalid = 2'b00;
        step();
        total++; if (grant_cnt !== {16'd3, 16'd5}) begin bad++; $display("FAIL stats_cnt got=%h want=00030005", grant_cnt); end
        s_tvalid  = 2'b01;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        s_tvalid  = 2'b00;
        total++; if (grant_cnt !== 32'h0) begin bad++; $display("FAIL stats_clr got=%h want=00000000", grant_cnt); end
        step();
    endtask
`endif

    initial begin
`ifdef STREAM_RR_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_fairness();
        test_idle_ptr();
        test_backpressure();
        test_mid_reset();
`ifdef STREAM_RR_ARBITER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
